// File: rtl/decode_ctrl_pipe.sv
// rtl/decode_ctrl_pipe.sv - LEGv8 ID stage: decode, ID/EX register, load-use hazard bubbles
module decode_ctrl_pipe #(
  parameter int         INSTR_W   = 32,
  parameter int         REG_AW    = 5,
  parameter int         ALU_OP_W  = 3,
  parameter logic [4:0] LT_COND   = 5'b01011,
  parameter bit         HAZARD_EN = 1'b1,
  parameter int         CNT_W     = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [INSTR_W-1:0]  id_instr,
  input  logic                id_valid,
  input  logic                stall_in,
  input  logic                flush,
  output logic                hazard_stall,
  output logic                ex_valid,
  output logic                ex_reg_write,
  output logic                ex_alu_src,
  output logic                ex_mem_read,
  output logic                ex_mem_write,
  output logic                ex_mem_to_reg,
  output logic                ex_flag_write,
  output logic                ex_branch,
  output logic                ex_branch_cond,
  output logic                ex_link,
  output logic                ex_illegal,
  output logic [ALU_OP_W-1:0] ex_alu_op,
  output logic [1:0]          ex_pc_src,
  output logic [REG_AW-1:0]   ex_rn,
  output logic [REG_AW-1:0]   ex_rm,
  output logic [REG_AW-1:0]   ex_rd,
  output logic [CNT_W-1:0]    bubble_count
);

  typedef struct packed {
    logic                reg_write;
    logic                alu_src;
    logic                mem_read;
    logic                mem_write;
    logic                mem_to_reg;
    logic                flag_write;
    logic                branch;
    logic                branch_cond;
    logic                link;
    logic                illegal;
    logic [ALU_OP_W-1:0] alu_op;
    logic [1:0]          pc_src;
  } ctrl_t;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(3);
  localparam logic [REG_AW-1:0]   XZR     = {REG_AW{1'b1}};
  localparam logic [REG_AW-1:0]   X30     = XZR - REG_AW'(1);

  logic [10:0] op11;
  logic [9:0]  op10;
  logic [7:0]  op8;
  logic [5:0]  op6;
  logic        unused_bits;

  assign op11        = id_instr[INSTR_W-1 -: 11];
  assign op10        = id_instr[INSTR_W-1 -: 10];
  assign op8         = id_instr[INSTR_W-1 -: 8];
  assign op6         = id_instr[INSTR_W-1 -: 6];
  assign unused_bits = ^id_instr[15:10];

  ctrl_t             dec;
  logic              use_rn, use_rm, rt_as_rm;
  logic [REG_AW-1:0] dec_rn, dec_rm, dec_rd;

  always_comb begin
    dec      = '0;
    use_rn   = 1'b0;
    use_rm   = 1'b0;
    rt_as_rm = 1'b0;
    if (op11 == 11'b10101011000) begin
      dec.reg_write = 1'b1; dec.flag_write = 1'b1; dec.alu_op = ALU_ADD;
      use_rn = 1'b1; use_rm = 1'b1;
    end else if (op11 == 11'b11101011000) begin
      dec.reg_write = 1'b1; dec.flag_write = 1'b1; dec.alu_op = ALU_SUB;
      use_rn = 1'b1; use_rm = 1'b1;
    end else if (op11 == 11'b11111000010) begin
      dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.mem_read = 1'b1;
      dec.mem_to_reg = 1'b1; dec.alu_op = ALU_ADD;
      use_rn = 1'b1;
    end else if (op11 == 11'b11111000000) begin
      dec.alu_src = 1'b1; dec.mem_write = 1'b1; dec.alu_op = ALU_ADD;
      use_rn = 1'b1; use_rm = 1'b1; rt_as_rm = 1'b1;
    end else if (op10 == 10'b1001000100) begin
      dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_op = ALU_ADD;
      use_rn = 1'b1;
    end else if (op6 == 6'b000101) begin
      dec.branch = 1'b1; dec.pc_src = 2'b01;
    end else if (op6 == 6'b100101) begin
      dec.branch = 1'b1; dec.link = 1'b1; dec.reg_write = 1'b1; dec.pc_src = 2'b01;
    end else if (op8 == 8'b10110100) begin
      dec.branch_cond = 1'b1; dec.pc_src = 2'b01;
      use_rm = 1'b1; rt_as_rm = 1'b1;
    end else if (op11 == 11'b11010110000) begin
      dec.pc_src = 2'b10;
      use_rn = 1'b1;
    end else if (op8 == 8'b01010100 && id_instr[4:0] == LT_COND) begin
      dec.branch_cond = 1'b1; dec.pc_src = 2'b01;
    end else begin
      dec.illegal = id_valid;
    end
  end

  // STUR and CBZ carry their data register (Rt) in the rd slot.
  assign dec_rn = id_instr[5 +: REG_AW];
  assign dec_rm = rt_as_rm ? id_instr[0 +: REG_AW] : id_instr[16 +: REG_AW];
  assign dec_rd = dec.link ? X30 : id_instr[0 +: REG_AW];

  logic              valid_q, valid_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic [REG_AW-1:0] rn_q, rn_d, rm_q, rm_d, rd_q, rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ex_hit;

  assign ex_hit = valid_q && ctrl_q.mem_read && (rd_q != XZR) &&
                  ((use_rn && dec_rn == rd_q) || (use_rm && dec_rm == rd_q));
  // Gated by reset so the freeze releases in the same cycle reset is seen.
  assign hazard_stall = HAZARD_EN && !reset && id_valid && ex_hit;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    rn_d    = rn_q;
    rm_d    = rm_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (flush || (!stall_in && (hazard_stall || !id_valid))) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      rn_d    = '0;
      rm_d    = '0;
      rd_d    = '0;
      if (!flush && hazard_stall && cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (!stall_in) begin
      valid_d = 1'b1;
      ctrl_d  = dec;
      rn_d    = dec_rn;
      rm_d    = dec_rm;
      rd_d    = dec_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      rn_q    <= '0;
      rm_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      rn_q    <= rn_d;
      rm_q    <= rm_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_valid       = valid_q;
  assign ex_reg_write   = ctrl_q.reg_write;
  assign ex_alu_src     = ctrl_q.alu_src;
  assign ex_mem_read    = ctrl_q.mem_read;
  assign ex_mem_write   = ctrl_q.mem_write;
  assign ex_mem_to_reg  = ctrl_q.mem_to_reg;
  assign ex_flag_write  = ctrl_q.flag_write;
  assign ex_branch      = ctrl_q.branch;
  assign ex_branch_cond = ctrl_q.branch_cond;
  assign ex_link        = ctrl_q.link;
  assign ex_illegal     = ctrl_q.illegal;
  assign ex_alu_op      = ctrl_q.alu_op;
  assign ex_pc_src      = ctrl_q.pc_src;
  assign ex_rn          = rn_q;
  assign ex_rm          = rm_q;
  assign ex_rd          = rd_q;
  assign bubble_count   = cnt_q;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// tb/tb_decode_ctrl_pipe.sv - scoreboard bench for decode_ctrl_pipe
module tb_decode_ctrl_pipe;

  logic        clk = 1'b0;
  logic        reset, id_valid, stall_in, flush;
  logic [31:0] id_instr;

  logic        hazard_stall, ex_valid, ex_reg_write, ex_alu_src, ex_mem_read, ex_mem_write;
  logic        ex_mem_to_reg, ex_flag_write, ex_branch, ex_branch_cond, ex_link, ex_illegal;
  logic [2:0]  ex_alu_op;
  logic [1:0]  ex_pc_src;
  logic [4:0]  ex_rn, ex_rm, ex_rd;
  logic [15:0] bubble_count;

  logic        s_hazard, s_valid, s_rw, s_as, s_mr, s_mw, s_mtr, s_fw, s_br, s_bc, s_lk, s_il;
  logic [2:0]  s_op;
  logic [1:0]  s_pc;
  logic [4:0]  s_rn, s_rm, s_rd;
  logic [1:0]  s_count;

  always #5 clk = ~clk;

  decode_ctrl_pipe dut (
    .clk(clk), .reset(reset), .id_instr(id_instr), .id_valid(id_valid),
    .stall_in(stall_in), .flush(flush), .hazard_stall(hazard_stall),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_alu_src(ex_alu_src),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_flag_write(ex_flag_write), .ex_branch(ex_branch), .ex_branch_cond(ex_branch_cond),
    .ex_link(ex_link), .ex_illegal(ex_illegal), .ex_alu_op(ex_alu_op), .ex_pc_src(ex_pc_src),
    .ex_rn(ex_rn), .ex_rm(ex_rm), .ex_rd(ex_rd), .bubble_count(bubble_count)
  );

  decode_ctrl_pipe #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .id_instr(id_instr), .id_valid(id_valid),
    .stall_in(stall_in), .flush(flush), .hazard_stall(s_hazard),
    .ex_valid(s_valid), .ex_reg_write(s_rw), .ex_alu_src(s_as),
    .ex_mem_read(s_mr), .ex_mem_write(s_mw), .ex_mem_to_reg(s_mtr),
    .ex_flag_write(s_fw), .ex_branch(s_br), .ex_branch_cond(s_bc),
    .ex_link(s_lk), .ex_illegal(s_il), .ex_alu_op(s_op), .ex_pc_src(s_pc),
    .ex_rn(s_rn), .ex_rm(s_rm), .ex_rd(s_rd), .bubble_count(s_count)
  );

  int checks = 0;
  int errors = 0;
  logic [29:0] exp_q[$];
  logic held = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // {reg_write,alu_src,mem_read,mem_write,mem_to_reg,flag_write,branch,branch_cond,link,illegal}
  function automatic logic [29:0] bund(input logic [9:0] c, input logic [2:0] op,
                                       input logic [1:0] pc, input logic [4:0] rn,
                                       input logic [4:0] rm, input logic [4:0] rd);
    return {c, op, pc, rn, rm, rd};
  endfunction

  function automatic logic [29:0] act_bund();
    return {ex_reg_write, ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_flag_write,
            ex_branch, ex_branch_cond, ex_link, ex_illegal, ex_alu_op, ex_pc_src,
            ex_rn, ex_rm, ex_rd};
  endfunction

  always @(posedge clk) held <= stall_in;

  always @(negedge clk) begin
    if (ex_valid === 1'b1 && !held) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue actual=%h expected=none", act_bund());
      end else begin
        chk("issue", {2'b00, act_bund()}, {2'b00, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic v);
    id_instr = ins;
    id_valid = v;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [29:0] e);
    drive(ins, 1'b1);
    exp_q.push_back(e);
    tick();
  endtask

  logic [31:0] LDUR3, ADDS, LDUR31, ADDS31, LDUR7, STUR7, CBZ7, B7, ADDI, SUBS;
  logic [29:0] E_LDUR3, E_ADDS, E_LDUR31, E_ADDS31, E_LDUR7, E_STUR7, E_CBZ7, E_B7, E_ADDI;
  logic [31:0] sw_ins[11];
  logic [29:0] sw_exp[11];
  int exp_cnt;

  initial begin
    LDUR3  = {11'b11111000010, 9'd0, 2'b00, 5'd1, 5'd3};
    E_LDUR3 = bund(10'b1110100000, 3'b010, 2'b00, 5'd1, 5'd0, 5'd3);
    ADDS   = {11'b10101011000, 5'd5, 6'd0, 5'd3, 5'd4};
    E_ADDS = bund(10'b1000010000, 3'b010, 2'b00, 5'd3, 5'd5, 5'd4);
    LDUR31 = {11'b11111000010, 9'd0, 2'b00, 5'd1, 5'd31};
    E_LDUR31 = bund(10'b1110100000, 3'b010, 2'b00, 5'd1, 5'd0, 5'd31);
    ADDS31 = {11'b10101011000, 5'd5, 6'd0, 5'd31, 5'd4};
    E_ADDS31 = bund(10'b1000010000, 3'b010, 2'b00, 5'd31, 5'd5, 5'd4);
    LDUR7  = {11'b11111000010, 9'd0, 2'b00, 5'd1, 5'd7};
    E_LDUR7 = bund(10'b1110100000, 3'b010, 2'b00, 5'd1, 5'd0, 5'd7);
    STUR7  = {11'b11111000000, 9'd8, 2'b00, 5'd2, 5'd7};
    E_STUR7 = bund(10'b0101000000, 3'b010, 2'b00, 5'd2, 5'd7, 5'd7);
    CBZ7   = {8'b10110100, 19'd3, 5'd7};
    E_CBZ7 = bund(10'b0000000100, 3'b000, 2'b01, 5'd3, 5'd7, 5'd7);
    B7     = {6'b000101, 26'd7};
    E_B7   = bund(10'b0000001000, 3'b000, 2'b01, 5'd0, 5'd0, 5'd7);
    ADDI   = {10'b1001000100, 12'd12, 5'd8, 5'd9};
    E_ADDI = bund(10'b1100000000, 3'b010, 2'b00, 5'd8, 5'd0, 5'd9);
    SUBS   = {11'b11101011000, 5'd3, 6'd0, 5'd2, 5'd1};

    sw_ins[0]  = ADDS;   sw_exp[0]  = E_ADDS;
    sw_ins[1]  = SUBS;   sw_exp[1]  = bund(10'b1000010000, 3'b011, 2'b00, 5'd2, 5'd3, 5'd1);
    sw_ins[2]  = LDUR3;  sw_exp[2]  = E_LDUR3;
    sw_ins[3]  = STUR7;  sw_exp[3]  = E_STUR7;
    sw_ins[4]  = ADDI;   sw_exp[4]  = E_ADDI;
    sw_ins[5]  = {6'b000101, 26'd4};
    sw_exp[5]  = bund(10'b0000001000, 3'b000, 2'b01, 5'd0, 5'd0, 5'd4);
    sw_ins[6]  = {6'b100101, 26'd8};
    sw_exp[6]  = bund(10'b1000001010, 3'b000, 2'b01, 5'd0, 5'd0, 5'd30);
    sw_ins[7]  = {8'b10110100, 19'd3, 5'd6};
    sw_exp[7]  = bund(10'b0000000100, 3'b000, 2'b01, 5'd3, 5'd6, 5'd6);
    sw_ins[8]  = {11'b11010110000, 5'd31, 6'd0, 5'd10, 5'd0};
    sw_exp[8]  = bund(10'b0000000000, 3'b000, 2'b10, 5'd10, 5'd31, 5'd0);
    sw_ins[9]  = {8'b01010100, 19'd2, 5'b01011};
    sw_exp[9]  = bund(10'b0000000100, 3'b000, 2'b01, 5'd2, 5'd0, 5'd11);
    sw_ins[10] = 32'h0;
    sw_exp[10] = bund(10'b0000000001, 3'b000, 2'b00, 5'd0, 5'd0, 5'd0);

    reset = 1'b1; stall_in = 1'b0; flush = 1'b0;
    drive($urandom, 1'b1);
    tick();
    drive($urandom, 1'b1);
    #1 chk("reset_hazard", {31'd0, hazard_stall}, 32'd0);
    tick();
    chk("reset_valid", {31'd0, ex_valid}, 32'd0);
    chk("reset_bundle", {2'b00, act_bund()}, 32'd0);
    chk("reset_count", {16'd0, bubble_count}, 32'd0);
    exp_cnt = 0;
    reset = 1'b0;
    drive(32'h0, 1'b0);
    tick();

    for (int i = 0; i < 11; i++) issue(sw_ins[i], sw_exp[i]);
    drive(32'h0, 1'b0);
    tick();

    issue(LDUR3, E_LDUR3);
    drive(ADDS, 1'b1);
    exp_q.push_back(E_ADDS);
    #1 chk("lu_hazard", {31'd0, hazard_stall}, 32'd1);
    tick();
    exp_cnt++;
    chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
    chk("lu_count", {16'd0, bubble_count}, exp_cnt);
    chk("lu_release", {31'd0, hazard_stall}, 32'd0);
    tick();
    drive(32'h0, 1'b0);
    tick();

    issue(LDUR31, E_LDUR31);
    drive(ADDS31, 1'b1);
    exp_q.push_back(E_ADDS31);
    #1 chk("xzr_nohazard", {31'd0, hazard_stall}, 32'd0);
    tick();
    drive(32'h0, 1'b0);
    tick();

    issue(LDUR3, E_LDUR3);
    drive(ADDS, 1'b1);
    stall_in = 1'b1;
    #1 chk("stall_hazard", {31'd0, hazard_stall}, 32'd1);
    tick();
    chk("stall_hold", {2'b00, act_bund()}, {2'b00, E_LDUR3});
    chk("stall_valid", {31'd0, ex_valid}, 32'd1);
    chk("stall_count", {16'd0, bubble_count}, exp_cnt);
    stall_in = 1'b0;
    flush = 1'b1;
    tick();
    chk("flush_hz_valid", {31'd0, ex_valid}, 32'd0);
    chk("flush_hz_count", {16'd0, bubble_count}, exp_cnt);
    flush = 1'b0;
    issue(ADDI, E_ADDI);
    drive(SUBS, 1'b1);
    stall_in = 1'b1;
    flush = 1'b1;
    tick();
    chk("flush_stall_valid", {31'd0, ex_valid}, 32'd0);
    chk("flush_stall_bundle", {2'b00, act_bund()}, 32'd0);
    stall_in = 1'b0;
    flush = 1'b0;
    drive(32'h0, 1'b0);
    tick();

    issue(LDUR7, E_LDUR7);
    drive(STUR7, 1'b1);
    exp_q.push_back(E_STUR7);
    #1 chk("stur_hazard", {31'd0, hazard_stall}, 32'd1);
    tick();
    exp_cnt++;
    chk("stur_count", {16'd0, bubble_count}, exp_cnt);
    tick();
    issue(LDUR7, E_LDUR7);
    drive(CBZ7, 1'b1);
    exp_q.push_back(E_CBZ7);
    #1 chk("cbz_hazard", {31'd0, hazard_stall}, 32'd1);
    tick();
    exp_cnt++;
    tick();
    issue(LDUR7, E_LDUR7);
    drive(B7, 1'b1);
    exp_q.push_back(E_B7);
    #1 chk("b_nohazard", {31'd0, hazard_stall}, 32'd0);
    tick();
    chk("b_count", {16'd0, bubble_count}, exp_cnt);
    drive(32'h0, 1'b0);
    tick();

    issue(LDUR3, E_LDUR3);
    drive(ADDS, 1'b1);
    #1 chk("pre_reset_hazard", {31'd0, hazard_stall}, 32'd1);
    reset = 1'b1;
    #1 chk("reset_drops_hazard", {31'd0, hazard_stall}, 32'd0);
    tick();
    exp_cnt = 0;
    chk("mid_reset_valid", {31'd0, ex_valid}, 32'd0);
    chk("mid_reset_count", {16'd0, bubble_count}, exp_cnt);
    reset = 1'b0;
    drive(32'h0, 1'b0);
    tick();

    for (int i = 0; i < 6; i++) begin
      issue(LDUR3, E_LDUR3);
      drive(ADDS, 1'b1);
      exp_q.push_back(E_ADDS);
      tick();
      exp_cnt++;
      tick();
      if (i == 4) begin
        chk("sat_count", {30'd0, s_count}, 32'd3);
        chk("wide_count5", {16'd0, bubble_count}, 32'd5);
      end
    end
    drive(32'h0, 1'b0);
    tick();
    chk("sat_hold", {30'd0, s_count}, 32'd3);
    chk("wide_count6", {16'd0, bubble_count}, exp_cnt);

    tick();
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
